multicycle_mem: RTL and testbench

MULTICYCLE_MEM -- requirements
Module: multicycle_mem

---
 rtl/mem_pkg.sv | 49 ++++
 rtl/mem_array.sv | 38 +++
 rtl/multicycle_mem.sv | 151 +++++++++++++++
 tb/tb_multicycle_mem.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// +-----------------------------------------------------------------------+
// | mem_pkg : shared Funct3 codes, FSM state type and access check helper |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // High when the access is misaligned or its Funct3 code is undefined.
   function automatic logic access_bad(input logic we, input logic [2:0] f3,
                                       input logic [1:0] a);
      logic bad;
      bad = 1'b1;
      if (we) begin
         case (f3)
            F3_SB:   bad = 1'b0;
            F3_SH:   bad = a[0];
            F3_SW:   bad = |a;
            default: bad = 1'b1;
         endcase
      end else begin
         case (f3)
            F3_LB, F3_LBU: bad = 1'b0;
            F3_LH, F3_LHU: bad = a[0];
            F3_LW:         bad = |a;
            default:       bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// +-----------------------------------------------------------------------+
// | mem_array : byte-lane writable synchronous RAM with registered read   |
// | Revision  : 1.0                                                       |
// +-----------------------------------------------------------------------+
`default_nettype none

module mem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64
) (
   input  logic                       clk_i,
   input  logic [DATA_W/8-1:0]        lane_we_i,
   input  logic [$clog2(DEPTH)-1:0]   waddr_i,
   input  logic [DATA_W-1:0]          wdata_i,
   input  logic [$clog2(DEPTH)-1:0]   raddr_i,
   output logic [DATA_W-1:0]          rdata_o
);

   localparam int LANES = DATA_W / 8;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Array contents deliberately have no reset.
   always_ff @(posedge clk_i) begin
      for (int l = 0; l < LANES; l++) begin
         if (lane_we_i[l]) begin
            mem_q[waddr_i][l*8 +: 8] <= wdata_i[l*8 +: 8];
         end
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/multicycle_mem.sv
// +-----------------------------------------------------------------------+
// | multicycle_mem : fixed-latency RISC-V style load/store memory         |
// | Revision       : 1.0                                                  |
// +-----------------------------------------------------------------------+
`default_nettype none

module multicycle_mem
   import mem_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 64,
   parameter int LATENCY = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Req,
   input  logic              WE,
   input  logic [2:0]        Funct3,
   input  logic [31:0]       A,
   input  logic [DATA_W-1:0] WD,
   output logic [DATA_W-1:0] RD,
   output logic              Ready,
   output logic              Busy,
   output logic              Err
);

   localparam int         AW     = $clog2(DEPTH);
   localparam int         LANES  = DATA_W / 8;
   localparam logic [2:0] C_LAST = 3'(LATENCY - 1);

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [AW+1:0]     a_q;
   logic [DATA_W-1:0] wd_q;
   logic [DATA_W-1:0] rd_q, rd_d;

   logic              w_accept, w_last, w_err, w_wr;
   logic [AW-1:0]     w_raddr;
   logic [DATA_W-1:0] w_rdata, w_wdata, w_load;
   logic [LANES-1:0]  w_lane_we;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic              w_unused_addr;

   assign w_accept      = (state_q == ST_IDLE) && Req;
   assign w_last        = (state_q == ST_WAIT) && (cnt_q == C_LAST);
   assign w_err         = access_bad(we_q, f3_q, a_q[1:0]);
   assign w_wr          = w_last && we_q && !w_err && !Reset;
   assign w_unused_addr = ^A[31:AW+2];

   // Address the array from the live input on the accept edge so the read
   // data is already valid during the first WAIT cycle.
   assign w_raddr = w_accept ? A[AW+1:2] : a_q[AW+1:2];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign w_wdata[l*8 +: 8] = (f3_q == F3_SB) ? wd_q[7:0] :
                                 (f3_q == F3_SH) ? wd_q[8*(l%2) +: 8] :
                                                   wd_q[l*8 +: 8];
      assign w_lane_we[l] = w_wr && ((f3_q == F3_SW) ||
                            ((f3_q == F3_SH) && ((l / 2) == int'(a_q[1]))) ||
                            ((f3_q == F3_SB) && (l == int'(a_q[1:0]))));
   end

   mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk_i     (Clk),
      .lane_we_i (w_lane_we),
      .waddr_i   (a_q[AW+1:2]),
      .wdata_i   (w_wdata),
      .raddr_i   (w_raddr),
      .rdata_o   (w_rdata)
   );

   assign w_byte = w_rdata[{a_q[1:0], 3'b000} +: 8];
   assign w_half = w_rdata[{a_q[1], 4'b0000} +: 16];

   always_comb begin
      w_load = '0;
      case (f3_q)
         F3_LB:   w_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
         F3_LH:   w_load = {{(DATA_W-16){w_half[15]}}, w_half};
         F3_LW:   w_load = w_rdata;
         F3_LBU:  w_load = {{(DATA_W-8){1'b0}}, w_byte};
         F3_LHU:  w_load = {{(DATA_W-16){1'b0}}, w_half};
         default: w_load = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      case (state_q)
         ST_IDLE: begin
            if (Req) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end
         end
         ST_WAIT: begin
            if (cnt_q == C_LAST) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               if (w_err) begin
                  rd_d = '0;
               end else if (!we_q) begin
                  rd_d = w_load;
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rd_q    <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         a_q     <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         if (w_accept) begin
            we_q <= WE;
            f3_q <= Funct3;
            a_q  <= A[AW+1:0];
            wd_q <= WD;
         end
      end
   end

   assign RD    = rd_q;
   assign Ready = (state_q == ST_DONE);
   assign Busy  = (state_q != ST_IDLE);
   assign Err   = Ready && w_err;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_mem.sv
// +-----------------------------------------------------------------------+
// | tb_multicycle_mem : scoreboard bench for multicycle_mem               |
// | Revision          : 1.0                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_mem;
   import mem_pkg::*;

   localparam int LAT = 3;

   typedef struct {
      logic [31:0] rd;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  f3 = '0;
   logic [31:0] a = '0;
   logic [31:0] wd = '0;
   logic [31:0] rd;
   logic        rdy, busy, err;

   logic        req1 = 1'b0;
   logic [31:0] rd1;
   logic        rdy1, busy1, err1;

   int          n_checks = 0;
   int          n_fail = 0;
   exp_t        sb_q[$];

   always #5 clk = ~clk;

   multicycle_mem #(.DATA_W(32), .DEPTH(64), .LATENCY(LAT)) u_dut (
      .Clk(clk), .Reset(rst), .Req(req), .WE(we), .Funct3(f3), .A(a), .WD(wd),
      .RD(rd), .Ready(rdy), .Busy(busy), .Err(err)
   );

   multicycle_mem #(.DATA_W(32), .DEPTH(64), .LATENCY(1)) u_dut1 (
      .Clk(clk), .Reset(rst), .Req(req1), .WE(1'b0), .Funct3(F3_LW),
      .A(32'h0), .WD(32'h0),
      .RD(rd1), .Ready(rdy1), .Busy(busy1), .Err(err1)
   );

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (err && !rdy) check_eq("err_without_ready", {31'b0, err}, 32'd0);
      if (err1 && !rdy1) check_eq("err1_without_ready", {31'b0, err1}, 32'd0);
      if (rdy) begin
         if (sb_q.size() == 0) begin
            check_eq("spurious_ready", {31'b0, rdy}, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq("rd", rd, e.rd);
            check_eq("err", {31'b0, err}, {31'b0, e.err});
         end
      end
   end

   // One transaction; inputs are scrambled and Req held during the wait to
   // show latching and that requests while busy are ignored.
   task automatic txn(input string tag, input logic t_we, input logic [2:0] t_f3,
                      input logic [31:0] t_a, input logic [31:0] t_wd,
                      input logic [31:0] exp_rd, input logic exp_err);
      int  n;
      bit  seen;
      @(negedge clk);
      req = 1'b1; we = t_we; f3 = t_f3; a = t_a; wd = t_wd;
      sb_q.push_back('{rd: exp_rd, err: exp_err});
      @(posedge clk);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (rdy) begin
            seen = 1'b1;
         end else begin
            check_eq({tag, "_busy"}, {31'b0, busy}, 32'd1);
            req = 1'b1;
            we  = 1'($urandom);
            f3  = 3'($urandom);
            a   = $urandom;
            wd  = $urandom;
         end
      end
      req = 1'b0;
      check_eq({tag, "_latency"}, seen ? 32'(n - 1) : 32'd99, 32'(LAT));
      if (seen) check_eq({tag, "_busy_at_ready"}, {31'b0, busy}, 32'd1);
   endtask

   initial begin
      int cnt;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("reset_ready", {31'b0, rdy}, 32'd0);
      check_eq("reset_busy", {31'b0, busy}, 32'd0);
      check_eq("reset_err", {31'b0, err}, 32'd0);
      check_eq("reset_rd", rd, 32'd0);
      rst = 1'b0;

      txn("sw10",    1'b1, F3_SW,  32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
      txn("lw10",    1'b0, F3_LW,  32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
      txn("sb11",    1'b1, F3_SB,  32'h11,  32'h80,       32'hDEADBEEF, 1'b0);
      txn("lb11",    1'b0, F3_LB,  32'h11,  32'h0,        32'hFFFFFF80, 1'b0);
      txn("lbu11",   1'b0, F3_LBU, 32'h11,  32'h0,        32'h00000080, 1'b0);
      txn("lw10b",   1'b0, F3_LW,  32'h10,  32'h0,        32'hDEAD80EF, 1'b0);
      txn("sh12",    1'b1, F3_SH,  32'h12,  32'h1234,     32'hDEAD80EF, 1'b0);
      txn("lhu12",   1'b0, F3_LHU, 32'h12,  32'h0,        32'h00001234, 1'b0);
      txn("lw13",    1'b0, F3_LW,  32'h13,  32'h0,        32'h0,        1'b1);
      txn("lw10c",   1'b0, F3_LW,  32'h10,  32'h0,        32'h123480EF, 1'b0);
      txn("sb13",    1'b1, F3_SB,  32'h13,  32'hF0,       32'h123480EF, 1'b0);
      txn("lh12",    1'b0, F3_LH,  32'h12,  32'h0,        32'hFFFFF034, 1'b0);
      txn("ld_ill",  1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1);
      txn("st_ill",  1'b1, 3'b100, 32'h10,  32'h55555555, 32'h0,        1'b1);
      txn("sw12",    1'b1, F3_SW,  32'h12,  32'h66666666, 32'h0,        1'b1);
      txn("sh11",    1'b1, F3_SH,  32'h11,  32'h7777,     32'h0,        1'b1);
      txn("lw10d",   1'b0, F3_LW,  32'h10,  32'h0,        32'hF03480EF, 1'b0);
      txn("sw100",   1'b1, F3_SW,  32'h100, 32'hA5A5A5A5, 32'hF03480EF, 1'b0);
      txn("lw0",     1'b0, F3_LW,  32'h0,   32'h0,        32'hA5A5A5A5, 1'b0);
      txn("lwhigh",  1'b0, F3_LW,  32'hFFFFFF00, 32'h0,   32'hA5A5A5A5, 1'b0);

      // Store aborted by reset one cycle after acceptance.
      @(negedge clk);
      req = 1'b1; we = 1'b1; f3 = F3_SW; a = 32'h10; wd = 32'h11111111;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0; rst = 1'b1;
      @(negedge clk);
      check_eq("abort_ready", {31'b0, rdy}, 32'd0);
      check_eq("abort_busy", {31'b0, busy}, 32'd0);
      check_eq("abort_err", {31'b0, err}, 32'd0);
      check_eq("abort_rd", rd, 32'd0);
      req = 1'b1; wd = 32'h22222222;
      @(negedge clk);
      rst = 1'b0; req = 1'b0;
      check_eq("req_in_reset_busy", {31'b0, busy}, 32'd0);
      repeat (5) begin
         @(negedge clk);
         check_eq("abort_no_ready", {31'b0, rdy}, 32'd0);
      end
      txn("lw_after_abort", 1'b0, F3_LW, 32'h10, 32'h0, 32'hF03480EF, 1'b0);

      // Continuous Req on the LATENCY=1 instance.
      cnt = 0;
      @(negedge clk);
      req1 = 1'b1;
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         if (n == 10) req1 = 1'b0;
         check_eq("tp_ready", {31'b0, rdy1}, ((n - 1) % 3 == 1 && n <= 11) ? 32'd1 : 32'd0);
         check_eq("tp_busy", {31'b0, busy1}, ((n - 1) % 3 != 2 && n <= 11) ? 32'd1 : 32'd0);
         if (rdy1) cnt++;
      end
      check_eq("tp_count", 32'(cnt), 32'd4);

      repeat (2) @(negedge clk);
      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
